line_data_mem: RTL and testbench

Parametrised line-organised data memory: the next-generation data RAM for the single-cycle core's load/store path and future cache refill. It stores DEPTH lines of WORDS_PER_LINE words and returns whole lines. It supports byte-strobed word writes and full-line writes, and has a valid/ready request handshake. Read latency is configurable and pipelined, and reset clears memory with a sequential sweep instead of a single-cycle array clear.

---
 rtl/line_data_mem.sv | 129 ++++++++++++
 tb/tb_line_data_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_data_mem.sv
// Line-organised data RAM: byte-strobed word writes, full-line writes, pipelined line reads,
// and a post-reset sweep that zeroes every line before requests are accepted.
module line_data_mem #(
   parameter int WORD_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int DEPTH          = 256,
   parameter int RD_LAT         = 1,
   localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
   localparam int OFF_W         = $clog2(WORDS_PER_LINE),
   localparam int IDX_W         = $clog2(DEPTH),
   localparam int AW            = IDX_W + OFF_W,
   localparam int SW            = WORD_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_line,
   input  logic [AW-1:0]     req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [SW-1:0]     req_wstrb,
   input  logic [LINE_W-1:0] req_line_wdata,
   output logic              rsp_valid,
   output logic [LINE_W-1:0] rsp_rdata,
   output logic              init_done
);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [IDX_W-1:0]  sweep;
   logic [LINE_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off;
   logic              accept;
   logic              rd_acc;
   logic              wr_word;
   logic              wr_line;

   logic              vld_p  [RD_LAT];
   logic [LINE_W-1:0] data_p [RD_LAT];

   function automatic logic [LINE_W-1:0] merge_word(
      input logic [LINE_W-1:0] line,
      input logic [OFF_W-1:0]  woff,
      input logic [WORD_W-1:0] wdata,
      input logic [SW-1:0]     wstrb
   );
      logic [LINE_W-1:0] merged;
      merged = line;
      for (int b = 0; b < SW; b++) begin
         if (wstrb[b]) begin
            merged[int'(woff)*WORD_W + 8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return merged;
   endfunction

   assign idx     = req_addr[AW-1:OFF_W];
   assign off     = req_addr[OFF_W-1:0];
   assign accept  = req_valid & req_ready;
   assign rd_acc  = accept & ~req_we;
   assign wr_word = accept & req_we & ~req_line;
   assign wr_line = accept & req_we & req_line;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= INIT;
         sweep     <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               sweep <= sweep + 1'b1;
               if (sweep == IDX_W'(DEPTH - 1)) begin
                  state     <= RUN;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               req_ready <= 1'b1;
               init_done <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   // The sweep owns the write port until RUN, so requests cannot collide with it.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[sweep] <= '0;
      end else if (wr_line) begin
         mem[idx] <= req_line_wdata;
      end else if (wr_word) begin
         mem[idx] <= merge_word(mem[idx], off, req_wdata, req_wstrb);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < RD_LAT; k++) begin
            vld_p[k]  <= 1'b0;
            data_p[k] <= '0;
         end
      end else begin
         // stage 0: line sampled at the acceptance edge, before any same-edge write lands
         vld_p[0] <= rd_acc;
         if (rd_acc) begin
            data_p[0] <= mem[idx];
         end
         // stages 1..RD_LAT-1: data advances only behind a valid so the last stage holds
         for (int k = 1; k < RD_LAT; k++) begin
            vld_p[k] <= vld_p[k-1];
            if (vld_p[k-1]) begin
               data_p[k] <= data_p[k-1];
            end
         end
      end
   end

   assign rsp_valid = vld_p[RD_LAT-1];
   assign rsp_rdata = data_p[RD_LAT-1];

endmodule

// File: tb/tb_line_data_mem.sv
// Directed plus randomized bench for line_data_mem against an array/queue reference model.
module tb_line_data_mem;

   localparam int WORD_W = 32;
   localparam int WPL    = 4;
   localparam int DEPTH  = 256;
   localparam int RD_LAT = 3;
   localparam int LINE_W = WORD_W * WPL;
   localparam int OFF_W  = $clog2(WPL);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int AW     = IDX_W + OFF_W;
   localparam int SW     = WORD_W / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic              req_line;
   logic [AW-1:0]     req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [SW-1:0]     req_wstrb;
   logic [LINE_W-1:0] req_line_wdata;
   logic              rsp_valid;
   logic [LINE_W-1:0] rsp_rdata;
   logic              init_done;

   always #5 clk = ~clk;

   line_data_mem #(
      .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_line(req_line),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_line_wdata(req_line_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done)
   );

   typedef struct {
      int                due;
      logic [LINE_W-1:0] data;
   } rsp_t;

   int                n_vec = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                init_cnt = 0;
   logic [LINE_W-1:0] ref_mem [DEPTH];
   rsp_t              rq [$];
   logic [LINE_W-1:0] last_rdata = '0;
   logic [LINE_W-1:0] pq [$];
   int                pc [$];
   int                acc;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] l;
      for (int k = 0; k < LINE_W / 32; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] rep(input logic [WORD_W-1:0] w);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < WPL; k++) l[WORD_W*k +: WORD_W] = w;
      return l;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      rq.delete();
      last_rdata = '0;
      init_cnt = 0;
   endtask

   // One clock: apply the model's view of what the edge accepted, then check outputs.
   task automatic tick();
      rsp_t              r;
      logic              rdy_before;
      logic              exp_v;
      int                idx;
      int                off;
      logic [WORD_W-1:0] w;
      rdy_before = (init_cnt >= DEPTH);
      @(posedge clk);
      cyc++;
      if (!rdy_before) begin
         init_cnt++;
      end else if (req_valid) begin
         idx = int'(req_addr) / WPL;
         off = int'(req_addr) % WPL;
         if (!req_we) begin
            r.due  = cyc + RD_LAT - 1;
            r.data = ref_mem[idx];
            rq.push_back(r);
         end else if (req_line) begin
            ref_mem[idx] = req_line_wdata;
         end else begin
            w = ref_mem[idx][WORD_W*off +: WORD_W];
            for (int b = 0; b < SW; b++) if (req_wstrb[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
            ref_mem[idx][WORD_W*off +: WORD_W] = w;
         end
      end
      #1;
      exp_v = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         exp_v = 1'b1;
         last_rdata = rq[0].data;
         void'(rq.pop_front());
      end
      chk("req_ready", LINE_W'(req_ready), LINE_W'(init_cnt >= DEPTH));
      chk("init_done", LINE_W'(init_done), LINE_W'(init_cnt >= DEPTH));
      chk("rsp_valid", LINE_W'(rsp_valid), LINE_W'(exp_v));
      chk("rsp_rdata", rsp_rdata, last_rdata);
      if (rsp_valid === 1'b1) begin
         pq.push_back(rsp_rdata);
         pc.push_back(cyc);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic ln, input logic [AW-1:0] a,
                        input logic [WORD_W-1:0] wd, input logic [SW-1:0] st,
                        input logic [LINE_W-1:0] lwd);
      req_valid = v; req_we = we; req_line = ln; req_addr = a;
      req_wdata = wd; req_wstrb = st; req_line_wdata = lwd;
      tick();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      drive(1'b1, 1'b0, 1'($urandom), a, $urandom, SW'($urandom), rnd_line());
   endtask

   task automatic wr_word(input logic [AW-1:0] a, input logic [WORD_W-1:0] wd, input logic [SW-1:0] st);
      drive(1'b1, 1'b1, 1'b0, a, wd, st, rnd_line());
   endtask

   task automatic wr_line(input logic [AW-1:0] a, input logic [LINE_W-1:0] lwd);
      drive(1'b1, 1'b1, 1'b1, a, $urandom, SW'($urandom), lwd);
   endtask

   task automatic drain();
      repeat (RD_LAT + 1) idle();
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_line = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; req_line_wdata = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", LINE_W'(req_ready), '0);
      chk("rst_init_done", LINE_W'(init_done), '0);
      chk("rst_rsp_valid", LINE_W'(rsp_valid), '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      reset = 1'b0;

      // 1: sweep with ignored writes, then an all-zero read of the last address
      repeat (DEPTH) drive(1'b1, 1'b1, 1'($urandom), AW'($urandom), $urandom, SW'($urandom), rnd_line());
      chk("t1_ready_after_sweep", LINE_W'(req_ready), LINE_W'(1));
      pq.delete(); pc.delete();
      rd(10'h3FF);
      acc = cyc;
      drain();
      chk("t1_pulses", LINE_W'(pq.size()), LINE_W'(1));
      if (pq.size() == 1) begin
         chk("t1_data", pq[0], '0);
         chk("t1_lat", LINE_W'(pc[0] - acc + 1), LINE_W'(RD_LAT));
      end

      // 2: strobed word write
      wr_word(10'h005, 32'hAABBCCDD, 4'b0101);
      pq.delete(); pc.delete();
      rd(10'h004);
      drain();
      chk("t2_pulses", LINE_W'(pq.size()), LINE_W'(1));
      if (pq.size() == 1) chk("t2_data", pq[0], 128'h00000000_00000000_00BB00DD_00000000);

      // 3: line write then immediate read
      wr_line(10'h008, 128'h44444444_33333333_22222222_11111111);
      pq.delete(); pc.delete();
      rd(10'h00B);
      acc = cyc;
      drain();
      chk("t3_pulses", LINE_W'(pq.size()), LINE_W'(1));
      if (pq.size() == 1) begin
         chk("t3_data", pq[0], 128'h44444444_33333333_22222222_11111111);
         chk("t3_lat", LINE_W'(pc[0] - acc + 1), LINE_W'(RD_LAT));
      end

      // 4: back-to-back reads of preloaded lines
      for (int k = 0; k < 4; k++) wr_line(AW'(k * WPL), rep(WORD_W'(k + 1)));
      pq.delete(); pc.delete();
      for (int k = 0; k < 4; k++) begin
         rd(AW'(k * WPL + $urandom_range(0, WPL - 1)));
         if (k == 0) acc = cyc;
      end
      drain();
      chk("t4_pulses", LINE_W'(pq.size()), LINE_W'(4));
      if (pq.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk("t4_data", pq[k], rep(WORD_W'(k + 1)));
            chk("t4_cycle", LINE_W'(pc[k] - acc + 1), LINE_W'(RD_LAT + k));
         end
      end

      // 5: write behind an in-flight read
      pq.delete(); pc.delete();
      rd(10'h008);
      wr_word(10'h009, 32'hDEADBEEF, 4'hF);
      rd(10'h008);
      drain();
      chk("t5_pulses", LINE_W'(pq.size()), LINE_W'(2));
      if (pq.size() == 2) begin
         chk("t5_old", pq[0], rep(32'd3));
         chk("t5_new", pq[1], 128'h00000003_00000003_DEADBEEF_00000003);
      end

      // random traffic concentrated on a few lines so writes and reads collide
      for (int i = 0; i < 600; i++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 8 * WPL - 1));
         case ($urandom_range(0, 3))
            0: idle();
            1: rd(a);
            2: wr_word(a, $urandom, SW'($urandom));
            default: wr_line(a, rnd_line());
         endcase
      end
      drain();

      // 6: reset with two reads in flight
      wr_word(10'h004, 32'h12345678, 4'hF);
      rd(10'h004);
      rd(10'h008);
      reset = 1'b1;
      #1;
      chk("t6_rsp_valid", LINE_W'(rsp_valid), '0);
      chk("t6_ready", LINE_W'(req_ready), '0);
      chk("t6_init_done", LINE_W'(init_done), '0);
      chk("t6_rsp_rdata", rsp_rdata, '0);
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      pq.delete(); pc.delete();
      repeat (DEPTH) idle();
      chk("t6_no_late_pulse", LINE_W'(pq.size()), '0);
      rd(10'h004);
      drain();
      chk("t6_pulses", LINE_W'(pq.size()), LINE_W'(1));
      if (pq.size() == 1) chk("t6_cleared", pq[0], '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
